ones_fill_gen: RTL
==================

ONES_FILL_GEN -- requirements
Module: ones_fill_gen

Interface
REQ-001 The block SHALL have parameter data_width, default 4, giving the generated word width in bits.
REQ-002 The block SHALL have parameter count_width, default 3, giving the requested-count width, with count_width >= clog2(data_width+1).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: a request is present on count_in.
REQ-006 Port in_ready, output, 1 bit: the block can accept a request.
REQ-007 Port count_in, input, count_width bits: requested number of ones.
REQ-008 Port data_out, output, data_width bits: the generated word.
REQ-009 Port out_valid, output, 1 bit: data_out and sat are the final result.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 Port sat, output, 1 bit: count_in exceeded data_width and was clamped.

Function
REQ-012 data_out SHALL hold exactly min(count_in, data_width) ones, packed at the least-significant end (thermometer code), so that a popcount of data_out equals the clamped request.
REQ-013 The FSM SHALL have exactly three states: IDLE, FILL and HOLD.
REQ-014 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in HOLD; both SHALL be registered-state decodes.
REQ-015 A request is accepted on a rising edge in IDLE with in_valid=1.
REQ-016 On that edge the block SHALL load remaining = min(count_in, data_width), clear data_out to 0, and set sat = (count_in > data_width).
REQ-017 On acceptance, the FSM SHALL go to FILL if remaining > 0, or directly to HOLD if remaining = 0.
REQ-018 Each FILL edge SHALL set data_out = {data_out[data_width-2:0], 1'b1} and decrement remaining; the edge that makes remaining 0 SHALL also move the FSM to HOLD.
REQ-019 Latency: for a request accepted on edge E with clamped count N, out_valid SHALL rise after edge E+N (N=0 gives out_valid in the cycle after E).
REQ-020 In FILL, data_out SHALL show the partial word; consumers SHALL sample it only when out_valid=1.
REQ-021 In HOLD, data_out and sat SHALL remain stable until a rising edge with out_ready=1, which SHALL return the FSM to IDLE.
REQ-022 data_out and sat SHALL keep their final values in IDLE until the next acceptance.
REQ-023 in_valid SHALL be ignored in FILL and HOLD; the request SHALL NOT be queued.
REQ-024 No request SHALL be accepted on the same edge a result is released, so the minimum request-to-request spacing is N+2 cycles.
REQ-025 remaining SHALL be count_width bits wide and SHALL never underflow.
REQ-026 A count_in of all ones SHALL clamp to data_width and set sat.

Reset
REQ-027 While reset=0, regardless of clk, the block SHALL force state=IDLE, data_out=0, remaining=0, sat=0 and out_valid=0, with in_ready=1.
REQ-028 Reset asserted in FILL or HOLD SHALL abort the operation and discard the partial result; no out_valid pulse SHALL follow.
REQ-029 After reset deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Verification (data_width=4, count_width=3)
REQ-030 Basic fill: count_in=3, in_valid pulsed at edge E, out_ready=1 -> out_valid rises after E+3, data_out=4'b0111, sat=0; IDLE after E+4.
REQ-031 Zero and full: count_in=0 -> out_valid in the cycle after E, data_out=4'b0000; count_in=4 -> data_out=4'b1111 after E+4, sat=0.
REQ-032 Saturation: count_in=6, then count_in=7 -> data_out=4'b1111 and sat=1 after E+4 in both cases.
REQ-033 Backpressure: count_in=2 with out_ready=0 for 5 cycles -> out_valid stays 1, data_out=4'b0011 stable, in_ready=0, a new in_valid is ignored; raising out_ready releases the result and returns in_ready=1 the next cycle.
REQ-034 Reset mid-operation: count_in=4, reset driven low between clk edges after 2 FILL edges -> outputs clear immediately (data_out=0, out_valid=0, in_ready=1); after release, count_in=1 -> data_out=4'b0001.
REQ-035 Cross-check: sweep count_in over 0..7 -> popcount(data_out) = min(count_in,4) at every out_valid, with exact latency per REQ-019.

Source files
------------

// File: rtl/ones_fill_gen.sv
//----------------------------------------------------------------------------
// ones_fill_gen
//
// Purpose:
//   Builds a thermometer-coded word holding min(count_in, data_width) ones,
//   packed at the least-significant end. One '1' is shifted in per clock
//   while filling. The finished word is then held with a valid/ready
//   handshake until the consumer takes it.
//
//   Flow: IDLE accepts a request -> FILL shifts in ones -> HOLD presents
//   the result. A zero-length request skips FILL and goes straight to HOLD.
//   A count larger than data_width is clamped, and this raises sat.
//
// Parameters:
//   data_width  - width of the generated word in bits
//   count_width - width of the requested count; must satisfy
//                 count_width >= clog2(data_width+1)
//
// Ports:
//   clk       in   single clock, rising-edge active
//   reset     in   asynchronous, active-low reset
//   in_valid  in   a request is present on count_in
//   in_ready  out  block is idle and can accept a request
//   count_in  in   requested number of ones
//   data_out  out  generated (or partially generated) word
//   out_valid out  data_out/sat hold the final result
//   out_ready in   consumer accepts the result
//   sat       out  request exceeded data_width and was clamped
//----------------------------------------------------------------------------
module ones_fill_gen #(
    parameter int data_width  = 4,
    parameter int count_width = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [count_width-1:0] count_in,
    output logic [data_width-1:0]  data_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    // data_width expressed in the count domain, used for clamping.
    localparam logic [count_width-1:0] FULL_COUNT = count_width'(data_width);

    // Constant 1 at word width.
    // Used to shift a '1' into the LSB without slicing data_out.
    // A slice such as data_out[data_width-2:0] would be illegal when data_width == 1.
    localparam logic [data_width-1:0] LSB_ONE = data_width'(1);

    state_t                 state;
    state_t                 next_state;
    logic [count_width-1:0] remaining;

    logic                   accept;
    logic                   over;
    logic [count_width-1:0] clamped;
    logic                   fill_done;

    // Request decode: acceptance only happens from IDLE.
    // Over-range requests are clamped to data_width.
    always_comb begin
        accept    = 1'b0;
        over      = 1'b0;
        clamped   = '0;
        fill_done = 1'b0;

        accept  = (state == IDLE) && in_valid;
        over    = (count_in > FULL_COUNT);
        clamped = over ? FULL_COUNT : count_in;
        // The FILL edge that consumes the last pending one also ends FILL.
        fill_done = (remaining <= count_width'(1));
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    // A zero-length request goes straight to HOLD, so the result appears one cycle after acceptance.
    // A result is released only by HOLD -> IDLE, so a new request cannot be accepted on the release edge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (clamped == '0) ? HOLD : FILL;
                end
            end
            FILL: begin
                if (fill_done) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath registers.
    // data_out and sat are written only on acceptance and during FILL.
    // They therefore stay put through HOLD and the following IDLE.
    // remaining is guarded so it can never wrap below zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out  <= '0;
            remaining <= '0;
            sat       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_out  <= '0;
                        remaining <= clamped;
                        sat       <= over;
                    end
                end
                FILL: begin
                    if (remaining != '0) begin
                        data_out  <= (data_out << 1) | LSB_ONE;
                        remaining <= remaining - count_width'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake flags are pure decodes of the registered state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;

        in_ready  = (state == IDLE);
        out_valid = (state == HOLD);
    end

endmodule
